// File: rtl/uart_mem_dump.sv
// uart_mem_dump: reads a run of 32-bit words from a synchronous-read memory
// port and transmits them as 8N1 UART frames. Bytes go out low byte first,
// and bits go out LSB first.
module uart_mem_dump #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 128_000,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [31:0]         shift_r, shift_s;
  logic [1:0]          byte_idx_r, byte_idx_s;
  logic [2:0]          bit_idx_r, bit_idx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [ADDR_W:0]     remain_r, remain_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic                tx_s, busy_s, done_s;
  logic [7:0]          cur_byte_s;

  // The byte on the wire is always the low byte of the shift word.
  assign cur_byte_s = shift_r[7:0];

  // Next-state and next-output logic for the fetch/serialize sequence.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    byte_idx_s = byte_idx_r;
    bit_idx_s  = bit_idx_r;
    cnt_s      = cnt_r;
    remain_s   = remain_r;
    mem_addr_s = mem_addr;
    tx_s       = tx;
    busy_s     = busy;
    done_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        if (start) begin
          mem_addr_s = base_addr;
          remain_s   = word_count;
          if (word_count != COUNT_ZERO) begin
            state_s = S_FETCH;
            busy_s  = 1'b1;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      // The memory samples mem_addr on this edge; data is usable in S_WAIT.
      S_FETCH: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        shift_s    = mem_rdata;
        byte_idx_s = 2'd0;
        bit_idx_s  = 3'd0;
        cnt_s      = CNT_ZERO;
        tx_s       = 1'b0;
        state_s    = S_START;
      end
      S_START: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s     = CNT_ZERO;
          bit_idx_s = 3'd0;
          tx_s      = cur_byte_s[0];
          state_s   = S_DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (bit_idx_r == 3'd7) begin
            tx_s    = 1'b1;
            state_s = S_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            tx_s      = cur_byte_s[bit_idx_r + 3'd1];
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (byte_idx_r != 2'd3) begin
            // Next byte of the same word follows with no idle gap.
            shift_s    = {8'h00, shift_r[31:8]};
            byte_idx_s = byte_idx_r + 2'd1;
            tx_s       = 1'b0;
            state_s    = S_START;
          end else if (remain_r > COUNT_ONE) begin
            remain_s   = remain_r - COUNT_ONE;
            mem_addr_s = mem_addr + ADDR_ONE;
            state_s    = S_FETCH;
          end else begin
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = S_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      shift_r    <= 32'h0000_0000;
      byte_idx_r <= 2'd0;
      bit_idx_r  <= 3'd0;
      cnt_r      <= CNT_ZERO;
      remain_r   <= COUNT_ZERO;
      mem_addr   <= ADDR_ZERO;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      byte_idx_r <= byte_idx_s;
      bit_idx_r  <= bit_idx_s;
      cnt_r      <= cnt_s;
      remain_r   <= remain_s;
      mem_addr   <= mem_addr_s;
      tx         <= tx_s;
      busy       <= busy_s;
      done       <= done_s;
    end
  end

endmodule

// File: doc/uart_mem_dump.md
# uart_mem_dump

Memory read-back transmitter: on command, reads a run of 32-bit words from a synchronous-read memory port (program ROM or data RAM read port) and serializes them over a UART TX line, 8N1, little-endian byte order. Counterpart to the UART programmer, which loads memory over `rx`; this block sends memory contents back out on `tx` for host-side verification of downloaded images and CPU results. Sits in the CPU top on the 10 MHz UART clock domain, muxed onto the board `tx` pin.

## Interface

Parameters:
- `CLK_FREQ`, 10_000_000: clock frequency in Hz.
- `BAUD`, 128_000: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division; must be ≥ 2).
- `ADDR_W`, 14: word-address width of the memory port.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: dump request, sampled each cycle; accepted only in IDLE.
- `base_addr`  in  ADDR_W: first word address, captured on accept.
- `word_count`  in  ADDR_W+1: number of words to send, captured on accept; 0 allowed.
- `mem_addr`  out  ADDR_W: registered word address to memory.
- `mem_rdata`  in  32: memory read data, valid the cycle after the memory samples `mem_addr`.
- `tx`  out  1: UART serial output, idle high.
- `busy`  out  1: high from accept until the final stop bit completes.
- `done`  out  1: one-cycle completion pulse.

## Operation

- Reset values: `tx`=1, `busy`=0, `done`=0, `mem_addr`=0; state IDLE; counters cleared.
- States: IDLE, FETCH, WAIT, START, DATA, STOP.
- IDLE: `tx`=1. On `start`=1: capture `base_addr` into `mem_addr`, `word_count` into remaining-word counter. If count ≠ 0 → FETCH, `busy`←1. If count = 0 → stay IDLE, `done`←1 for one cycle, `busy` stays 0.
- FETCH: memory samples `mem_addr`; → WAIT.
- WAIT: load `mem_rdata` into 32-bit shift word, byte index←0, `tx`←0; → START.
- START: hold `tx`=0 for CLKS_PER_BIT cycles; → DATA with `tx`←bit 0.
- DATA: 8 bits of current byte, LSB first, CLKS_PER_BIT cycles each; → STOP with `tx`←1.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then:
  - byte index < 3: shift word right 8, index+1, `tx`←0, → START (no idle gap between bytes of a word).
  - byte index = 3, words remaining > 1: decrement, `mem_addr`←`mem_addr`+1 mod 2^ADDR_W, → FETCH.
  - last byte of last word: → IDLE, `busy`←0, `done`←1 for one cycle.
- Byte order per word: `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- Address wrap: `mem_addr` increments modulo 2^ADDR_W (0x3FFF → 0x0000 for ADDR_W=14).
- `start` while not IDLE: ignored, no effect on captured values. `base_addr`/`word_count` changes after accept: ignored.
- `rst`=0 at any point including mid-frame: next edge returns to reset values, `tx` high; no partial frame completion, no `done`.

## Timing

- `start` accepted at edge N → `busy`=1 and `mem_addr`=base after N; FETCH during N..N+1; WAIT N+1..N+2; `tx` falls (start bit) after edge N+2. Latency accept→start bit: 2 cycles.
- Frame: exactly 10·CLKS_PER_BIT cycles (start + 8 data + stop).
- Word: 40·CLKS_PER_BIT cycles; inter-word gap: 2 extra `tx`-high cycles (FETCH, WAIT) after a word's final stop bit.
- Dump of K≥1 words: `done` asserted 2 + K·40·CLKS_PER_BIT + 2·(K−1) cycles after accept edge; `busy` falls on the same edge `done` rises.
- Zero-count: `done` high the cycle after accept.
- New `start` accepted the cycle `done` is high (state already IDLE).

## Test plan

- CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16); mem[0]=0x12345678, start base=0 count=1 → bytes 0x78,0x56,0x34,0x12 on `tx`, LSB first, each bit 16 cycles, stop bits high; `done` pulse at cycle 2+640 after accept.
- base=0x3FFF, count=2, mem[0x3FFF]=0xA5A5A5A5, mem[0]=0x0000_00FF → `mem_addr` sequence 0x3FFF, 0x0000; 8 bytes A5×4, FF,00,00,00; 2-cycle high gap between words.
- count=0 → `done` one cycle after accept, `busy` never high, `tx` constant 1.
- Second `start` pulse mid-dump with different base/count → ignored; output identical to single-start run; `done` pulses once.
- `rst`=0 during DATA of byte 2 → `tx`=1, `busy`=0, `mem_addr`=0 after next edge; no `done`; subsequent start dumps correctly from its base.
- Back-to-back: `start` held high continuously, count=1 → second dump accepted on the `done` cycle, start bit 2 cycles later.
